// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a word data memory.
// Also detects misaligned accesses and keeps a saturating count of them.
package mem_pkg;
  typedef struct packed {
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        link;
    logic [4:0]  wraddr;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [31:0] pc_4;
  } ex_mem_t;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  wraddr;
    logic [31:0] data;
  } mem_wb_t;
endpackage

module mem_stage #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] EX_alu_res,
  input  logic [31:0] EX_store_data,
  input  logic [4:0]  EX_wraddr,
  input  logic [31:0] EX_pc_4,
  input  logic        EX_regwrite,
  input  logic        EX_memread,
  input  logic        EX_memwrite,
  input  logic        EX_memtoreg,
  input  logic        EX_link,
  output logic        MEM_regwrite,
  output logic        MEM_memread,
  output logic [4:0]  MEM_wraddr,
  output logic [31:0] MEM_fwd_data,
  output logic        WB_regwrite,
  output logic [4:0]  WB_wraddr,
  output logic [31:0] WB_data,
  output logic        misalign,
  output logic [7:0]  misalign_cnt
);
  import mem_pkg::*;

  ex_mem_t em;
  ex_mem_t em_d;
  mem_wb_t mw;

  logic [31:0]       mem [MEM_DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;
  logic [31:0]       wb_val;
  logic              we;

  always_comb begin
    em_d            = '0;
    em_d.regwrite   = EX_regwrite;
    em_d.memread    = EX_memread;
    em_d.memwrite   = EX_memwrite;
    em_d.memtoreg   = EX_memtoreg;
    em_d.link       = EX_link;
    em_d.wraddr     = EX_wraddr;
    em_d.alu_res    = EX_alu_res;
    em_d.store_data = EX_store_data;
    em_d.pc_4       = EX_pc_4;
  end

  // flush wins over hold so a stalled slot can still be squashed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     em <= '0;
    else if (flush) em <= '0;
    else if (!hold) em <= em_d;
  end

  assign idx      = em.alu_res[ADDR_W+1:2];
  assign misalign = (em.memread | em.memwrite)
                  & (em.alu_res[1:0] != 2'b00);
  assign we       = em.memwrite & ~misalign & ~hold & rst_n;

  // read-before-write: the old word is seen in the cycle of the store
  assign rdata = misalign ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= em.store_data;
  end

  always_comb begin
    wb_val = em.alu_res;
    if (em.link)          wb_val = em.pc_4;
    else if (em.memtoreg) wb_val = rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mw <= '0;
    end else if (!hold) begin
      mw.regwrite <= em.regwrite;
      mw.wraddr   <= em.wraddr;
      mw.data     <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_cnt <= '0;
    else if (misalign && !hold && misalign_cnt != 8'hFF)
      misalign_cnt <= misalign_cnt + 8'd1;
  end

  assign MEM_regwrite = em.regwrite;
  assign MEM_memread  = em.memread;
  assign MEM_wraddr   = em.wraddr;
  assign MEM_fwd_data = em.link ? em.pc_4 : em.alu_res;

  assign WB_regwrite = mw.regwrite & (mw.wraddr != 5'd0);
  assign WB_wraddr   = mw.wraddr;
  assign WB_data     = mw.data;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks,
// a negedge monitor pops them as WB_regwrite presents new results.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_sd = '0;
  logic [31:0] ex_pc4 = '0;
  logic [4:0]  ex_wa = '0;
  logic        ex_rw = 1'b0;
  logic        ex_mr = 1'b0;
  logic        ex_mw = 1'b0;
  logic        ex_m2r = 1'b0;
  logic        ex_lk = 1'b0;

  logic        MEM_regwrite;
  logic        MEM_memread;
  logic [4:0]  MEM_wraddr;
  logic [31:0] MEM_fwd_data;
  logic        WB_regwrite;
  logic [4:0]  WB_wraddr;
  logic [31:0] WB_data;
  logic        misalign;
  logic [7:0]  misalign_cnt;

  mem_stage #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .EX_alu_res(ex_alu), .EX_store_data(ex_sd),
    .EX_wraddr(ex_wa), .EX_pc_4(ex_pc4),
    .EX_regwrite(ex_rw), .EX_memread(ex_mr),
    .EX_memwrite(ex_mw), .EX_memtoreg(ex_m2r),
    .EX_link(ex_lk),
    .MEM_regwrite(MEM_regwrite), .MEM_memread(MEM_memread),
    .MEM_wraddr(MEM_wraddr), .MEM_fwd_data(MEM_fwd_data),
    .WB_regwrite(WB_regwrite), .WB_wraddr(WB_wraddr),
    .WB_data(WB_data), .misalign(misalign),
    .misalign_cnt(misalign_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic held = 1'b1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic lk,
                        input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [31:0] pc4);
    ex_rw = rw; ex_mr = mr; ex_mw = mw; ex_m2r = m2r; ex_lk = lk;
    ex_wa = wa; ex_alu = alu; ex_sd = sd; ex_pc4 = pc4;
  endtask

  task automatic drive(input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic lk,
                       input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] pc4,
                       input logic [31:0] exp);
    exp_t e;
    set_ex(rw, mr, mw, m2r, lk, wa, alu, sd, pc4);
    if (rw && wa != 5'd0) begin
      e.a = wa;
      e.d = exp;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, a, d, '0, '0);
  endtask

  task automatic lw(input logic [31:0] a, input logic [4:0] rd,
                    input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rd, a, '0, '0, exp);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] v);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd, v, '0, '0, v);
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0, '0);
  endtask

  // a held MEM/WB shows the same result again; only count fresh ones
  always @(posedge clk) held <= hold;

  always @(negedge clk) begin
    if (rst_n && WB_regwrite && !held) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_spurious: got r%0d=%h expected none",
                 WB_wraddr, WB_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_wraddr", 32'(WB_wraddr), 32'(mon_e.a));
        chk("wb_data", WB_data, mon_e.d);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_wb_regwrite", 32'(WB_regwrite), 32'd0);
    chk("rst_wb_data", WB_data, 32'd0);
    chk("rst_mem_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("rst_cnt", 32'(misalign_cnt), 32'd0);
    rst_n = 1'b1;

    sw(32'h10, 32'hDEADBEEF);
    lw(32'h10, 5'd5, 32'hDEADBEEF);
    chk("mem_memread", 32'(MEM_memread), 32'd1);
    chk("mem_wraddr", 32'(MEM_wraddr), 32'd5);
    chk("mem_regwrite", 32'(MEM_regwrite), 32'd1);
    bubble();
    chk("lw_latency_data", WB_data, 32'hDEADBEEF);
    chk("lw_latency_rw", 32'(WB_regwrite), 32'd1);

    lw(32'h13, 5'd6, 32'h0);
    chk("misalign_lw", 32'(misalign), 32'd1);
    chk("cnt_before", 32'(misalign_cnt), 32'd0);
    sw(32'h20, 32'hCAFEF00D);
    chk("cnt_after_lw", 32'(misalign_cnt), 32'd1);
    chk("aligned_sw", 32'(misalign), 32'd0);
    sw(32'h22, 32'h12345678);
    chk("misalign_sw", 32'(misalign), 32'd1);
    lw(32'h20, 5'd7, 32'hCAFEF00D);
    chk("cnt_after_sw", 32'(misalign_cnt), 32'd2);

    sw(32'h30, 32'h11111111);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h30,
          32'h22222222, '0, 32'h11111111);
    lw(32'h30, 5'd9, 32'h22222222);

    alu(5'd3, 32'h55);
    chk("fwd_alu", MEM_fwd_data, 32'h55);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 32'h1234,
          '0, 32'h44, 32'h44);
    chk("fwd_jal", MEM_fwd_data, 32'h44);
    bubble();
    chk("jal_wb", WB_data, 32'h44);

    sw(32'h40, 32'h0BADF00D);
    alu(5'd12, 32'h99);
    sw(32'h40, 32'hAAAA5555);
    hold = 1'b1;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h77, '0, '0);
    repeat (3) @(negedge clk);
    chk("hold_wb_data", WB_data, 32'h99);
    chk("hold_wb_wraddr", 32'(WB_wraddr), 32'd12);
    chk("hold_fwd", MEM_fwd_data, 32'h40);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_fwd", MEM_fwd_data, 32'h0);
    chk("flush_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("flush_hold_wb", WB_data, 32'h99);
    hold = 1'b0;
    flush = 1'b0;
    lw(32'h40, 5'd11, 32'h0BADF00D);

    sw(32'h400, 32'h5A5A5A5A);
    lw(32'h0, 5'd13, 32'h5A5A5A5A);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h123, '0, '0, '0);
    bubble();
    chk("r0_regwrite", 32'(WB_regwrite), 32'd0);

    for (int i = 0; i < 300; i++)
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h101, '0, '0, '0);
    bubble();
    bubble();
    chk("cnt_saturate", 32'(misalign_cnt), 32'd255);

    sw(32'h50, 32'h13572468);
    alu(5'd14, 32'h66);
    sw(32'h50, 32'hFFFFFFFF);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_data", WB_data, 32'h0);
    chk("arst_wb_wraddr", 32'(WB_wraddr), 32'd0);
    chk("arst_fwd", MEM_fwd_data, 32'h0);
    chk("arst_cnt", 32'(misalign_cnt), 32'd0);
    chk("arst_misalign", 32'(misalign), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lw(32'h50, 5'd15, 32'h13572468);
    bubble();
    chk("post_rst_wb", WB_data, 32'h13572468);
    chk("post_rst_wraddr", 32'(WB_wraddr), 32'd15);
    bubble();
    bubble();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
